bf_cfg_loader: RTL and testbench
================================

Name: bf_cfg_loader

Overview:
- Writer side of the butterfly-network config interface.
- Accepts per-stage switch-config words over a valid/ready stream.
- Assembles them into a shadow bank, then atomically swaps the shadow into an active bank.
- The active bank drives the config_data inputs of all cascaded 2x2 butterfly stages, so the permutation changes only at a safe boundary and never mid-packet.

Parameters:
- DATA_WIDTH, 32, width of the datapath being permuted; each stage consumes DATA_WIDTH/2 config bits.
- STAGE_NUM, 9, number of cascaded stages to configure (2*log2(DATA_WIDTH)-1 for a Benes network).
- CNT_W, 4, width of the stage-word counter; must satisfy 2**CNT_W >= STAGE_NUM.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- s_valid  input  1  config word valid.
- s_ready  output  1  loader can accept a word.
- s_data  input  DATA_WIDTH/2  config word for one stage; word k targets stage k.
- s_last  input  1  marks the final word of a config set.
- swap_en  input  1  safe-boundary strobe (e.g. between packets); permits shadow→active swap.
- cfg_active  output  STAGE_NUM*DATA_WIDTH/2  active config; stage k uses bits [k*DATA_WIDTH/2 +: DATA_WIDTH/2].
- cfg_pending  output  1  complete shadow set waiting for swap_en.
- cfg_err  output  1  one-cycle pulse on a malformed config set.
- cfg_epoch  output  8  count of completed swaps, wraps 255→0.

Behaviour:
- Reset (rst=0 at posedge):
  - cfg_active all zeros, i.e. every switch in pass-through, giving an identity permutation.
  - shadow zeros, counter 0, FSM=LOAD.
  - s_ready=1 the first cycle after reset; cfg_pending=0, cfg_err=0, cfg_epoch=0.
- Reset mid-load discards any partial shadow; cfg_active reverts to zeros.
- Handshake: a word transfers when s_valid&s_ready at posedge. s_data/s_last are ignored otherwise.
- States:
  - LOAD: s_ready=1. On transfer, write shadow[cnt] and increment cnt.
    - s_last with cnt==STAGE_NUM-1: go to PEND, set cfg_pending, reset cnt to 0.
    - s_last with cnt<STAGE_NUM-1 (short set): pulse cfg_err, discard the shadow (cleared to zeros), reset cnt, stay in LOAD.
    - cnt==STAGE_NUM-1 without s_last (long set): pulse cfg_err, go to DRAIN.
  - PEND: s_ready=0; shadow is held stable. When swap_en=1, cfg_active<=shadow on that edge, cfg_pending clears, cfg_epoch increments, go to LOAD. The new config is visible the cycle after swap_en is sampled.
  - DRAIN: s_ready=1. Words are accepted and dropped. A transfer with s_last returns the FSM to LOAD with cnt=0 and shadow cleared. No further cfg_err pulses while draining.
- Simultaneous events:
  - swap_en is ignored in LOAD and DRAIN.
  - Commit and swap_en in the same cycle: the commit wins and no swap happens. The earliest swap is the cycle after cfg_pending rises.
  - swap_en held high is harmless; only one swap occurs per commit.
- Latency: final word accepted at cycle N gives cfg_pending=1 at N+1. swap_en at M≥N+1 gives new cfg_active at M+1.
- cfg_active changes only on a swap or on reset.
- cfg_active is a registered output; downstream stages may add their own pipeline registers.
- cfg_err is registered and high for exactly one cycle per malformed set.

Decomposition:
- Shared package, bf_pkg:
  - localparams STAGE_CFG_W = DATA_WIDTH/2 and BENES_STAGES(DATA_WIDTH).
  - FSM state encoding LOAD=2'd0, PEND=2'd1, DRAIN=2'd2.
  - Stage-slice index helper.
- One natural sub-module, bf_cfg_bank: a STAGE_NUM x STAGE_CFG_W shadow register file with indexed write, clear, and a flattened read. The FSM, active register and counters stay in bf_cfg_loader.

Test Plan:
- Reset, then idle: cfg_active==0, s_ready==1, cfg_pending==0, cfg_epoch==0. With cfg_active feeding a 32-bit network, din 0x12345678 gives dout 0x12345678.
- Send 9 words 0x0001..0x0009 with s_last on the 9th, then pulse swap_en 3 cycles later:
  - cfg_pending=1 from the cycle after word 9; s_ready=0 while pending.
  - One cycle after swap_en: stage k slice == k+1, cfg_epoch==1.
- Short set: 4 words with s_last on the 4th → one-cycle cfg_err, stay LOAD, cfg_active unchanged. A following valid 9-word set with swap loads correctly.
- Long set: 11 words, s_last on the 11th → cfg_err pulses once when the 9th word is accepted without s_last; words 10–11 are dropped; state returns to LOAD; cfg_pending stays 0.
- swap_en asserted on the same cycle the last word transfers → no swap. swap_en held for 5 more cycles → exactly one swap, cfg_epoch +1.
- Reset asserted mid-load after word 5 → cfg_active==0, cnt==0. A subsequent full set plus swap behaves as in scenario 2. Also run 256 swaps → cfg_epoch wraps to 0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the butterfly-network config loader.
//   STAGE_CFG_W  : config bits consumed by one stage of the default 32-bit network
//   BENES_STAGES : stage count of a Benes network of the default width
//   state_e      : loader FSM encoding
//   stage_lsb    : LSB of stage k's slice in a flattened config vector
package bf_pkg;

  localparam int unsigned BF_DATA_WIDTH = 32;
  localparam int unsigned STAGE_CFG_W   = BF_DATA_WIDTH / 2;

  function automatic int unsigned benes_stages(input int unsigned dw);
    return 2 * $clog2(dw) - 1;
  endfunction

  localparam int unsigned BENES_STAGES = benes_stages(BF_DATA_WIDTH);

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StPend  = 2'd1,
    StDrain = 2'd2
  } state_e;

  function automatic int unsigned stage_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/bf_cfg_loader_if.sv
// Config-word stream between a config source (master) and the loader (slave).
//   s_valid : word valid            (master -> slave)
//   s_ready : loader can accept     (slave  -> master)
//   s_data  : one stage config word (master -> slave)
//   s_last  : final word of a set   (master -> slave)
interface bf_cfg_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH/2-1:0] s_data;
  logic                    s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/bf_cfg_bank.sv
// Shadow register file: STAGE_NUM words of CFG_W bits.
//   clk, rst : clock, synchronous active-low reset
//   we/waddr/wdata : indexed word write
//   clr      : clear all words to zero (wins over a write in the same cycle)
//   rdata    : flattened contents, word k at [k*CFG_W +: CFG_W]
module bf_cfg_bank
  import bf_pkg::*;
#(
  parameter int unsigned STAGE_NUM = 9,
  parameter int unsigned CFG_W     = 16,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [CNT_W-1:0]           waddr,
  input  logic [CFG_W-1:0]           wdata,
  input  logic                       clr,
  output logic [STAGE_NUM*CFG_W-1:0] rdata
);

  logic [CFG_W-1:0] mem_q [STAGE_NUM];

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      for (int k = 0; k < STAGE_NUM; k++) begin
        mem_q[k] <= '0;
      end
    end else if (we && (32'(waddr) < STAGE_NUM)) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < STAGE_NUM; k++) begin
      rdata[stage_lsb(k, CFG_W) +: CFG_W] = mem_q[k];
    end
  end

endmodule

// File: rtl/bf_cfg_loader.sv
// Writer side of the butterfly-network config interface. Collects one config word
// per stage into a shadow bank, then copies the whole bank into the active config
// on a safe-boundary strobe so the permutation never changes mid-packet.
//   clk, rst    : clock, synchronous active-low reset
//   bus         : config-word stream (slave side)
//   swap_en     : safe-boundary strobe permitting shadow -> active swap
//   cfg_active  : active config, stage k at [k*DATA_WIDTH/2 +: DATA_WIDTH/2]
//   cfg_pending : complete shadow set waiting for swap_en
//   cfg_err     : one-cycle pulse per malformed (short or long) set
//   cfg_epoch   : completed swap count, wraps
module bf_cfg_loader
  import bf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGE_NUM  = 9,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  bf_cfg_loader_if.slave                    bus,
  input  logic                              swap_en,
  output logic [STAGE_NUM*DATA_WIDTH/2-1:0] cfg_active,
  output logic                              cfg_pending,
  output logic                              cfg_err,
  output logic [7:0]                        cfg_epoch
);

  localparam int unsigned CfgW = DATA_WIDTH / 2;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(STAGE_NUM - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [7:0]                epoch_q;
  logic [STAGE_NUM*CfgW-1:0] active_q;
  logic [STAGE_NUM*CfgW-1:0] shadow;

  logic xfer;
  logic bank_we;
  logic bank_clr;
  logic swap;

  assign bus.s_ready = (state_q != StPend);
  assign xfer        = bus.s_valid & bus.s_ready;

  bf_cfg_bank #(
    .STAGE_NUM (STAGE_NUM),
    .CFG_W     (CfgW),
    .CNT_W     (CNT_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .waddr (cnt_q),
    .wdata (bus.s_data),
    .clr   (bank_clr),
    .rdata (shadow)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    bank_we  = 1'b0;
    bank_clr = 1'b0;
    swap     = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (xfer) begin
          bank_we = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (bus.s_last) begin
            cnt_d = '0;
            if (cnt_q == LastIdx) begin
              state_d = StPend;
            end else begin
              // Short set: drop the partial shadow so the next set starts clean.
              err_d    = 1'b1;
              bank_clr = 1'b1;
            end
          end else if (cnt_q == LastIdx) begin
            // Long set: swallow the rest of it up to its s_last.
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = StDrain;
          end
        end
      end
      StPend: begin
        if (swap_en) begin
          swap    = 1'b1;
          state_d = StLoad;
        end
      end
      StDrain: begin
        if (xfer && bus.s_last) begin
          bank_clr = 1'b1;
          cnt_d    = '0;
          state_d  = StLoad;
        end
      end
      default: begin
        bank_clr = 1'b1;
        cnt_d    = '0;
        state_d  = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StLoad;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      epoch_q  <= 8'd0;
      active_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (swap) begin
        active_q <= shadow;
        epoch_q  <= epoch_q + 8'd1;
      end
    end
  end

  assign cfg_active  = active_q;
  assign cfg_pending = (state_q == StPend);
  assign cfg_err     = err_q;
  assign cfg_epoch   = epoch_q;

endmodule

// File: tb/tb_bf_cfg_loader.sv
module tb_bf_cfg_loader;

  localparam int DW = 32;
  localparam int SN = 9;
  localparam int CW = 4;
  localparam int W  = DW / 2;
  localparam int AW = SN * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          swap_en = 1'b0;
  logic [AW-1:0] cfg_active;
  logic          cfg_pending;
  logic          cfg_err;
  logic [7:0]    cfg_epoch;

  bf_cfg_loader_if #(.DATA_WIDTH(DW)) bus ();

  bf_cfg_loader #(
    .DATA_WIDTH (DW),
    .STAGE_NUM  (SN),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .swap_en     (swap_en),
    .cfg_active  (cfg_active),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err),
    .cfg_epoch   (cfg_epoch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        sw;
    logic        rdy;
    logic        pend;
    logic        err;
    logic [7:0]  ep;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic l, input logic sw);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    swap_en     = sw;
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic v, input logic [15:0] d, input logic l,
                               input logic sw, input logic rdy, input logic pend,
                               input logic err, input logic [7:0] ep);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.sw = sw;
    x.rdy = rdy; x.pend = pend; x.err = err; x.ep = ep;
    tbl.push_back(x);
  endfunction

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].sw);
      chk($sformatf("%s[%0d] s_ready", tag, i), AW'(bus.s_ready), AW'(tbl[i].rdy));
      chk($sformatf("%s[%0d] cfg_pending", tag, i), AW'(cfg_pending), AW'(tbl[i].pend));
      chk($sformatf("%s[%0d] cfg_err", tag, i), AW'(cfg_err), AW'(tbl[i].err));
      chk($sformatf("%s[%0d] cfg_epoch", tag, i), AW'(cfg_epoch), AW'(tbl[i].ep));
    end
    tbl.delete();
  endtask

  // Stage k word = base + k.
  function automatic logic [AW-1:0] exp_set(input int base);
    logic [AW-1:0] r;
    r = '0;
    for (int k = 0; k < SN; k++) r[k*W +: W] = 16'(base + k);
    return r;
  endfunction

  // Minimal 2x2-switch network: a set bit swaps its bit pair in that stage.
  function automatic logic [DW-1:0] net(input logic [DW-1:0] din, input logic [AW-1:0] cfg);
    logic [DW-1:0] r;
    logic          t;
    r = din;
    for (int k = 0; k < SN; k++) begin
      for (int j = 0; j < W; j++) begin
        if (cfg[k*W + j]) begin
          t          = r[2*j];
          r[2*j]     = r[2*j + 1];
          r[2*j + 1] = t;
        end
      end
    end
    return r;
  endfunction

  task automatic send_full(input int base);
    for (int i = 0; i < SN; i++) cyc(1'b1, 16'(base + i), (i == SN - 1), 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " cfg_active"}, cfg_active, '0);
    chk({tag, " s_ready"}, AW'(bus.s_ready), AW'(1'b1));
    chk({tag, " cfg_pending"}, AW'(cfg_pending), '0);
    chk({tag, " cfg_err"}, AW'(cfg_err), '0);
    chk({tag, " cfg_epoch"}, AW'(cfg_epoch), '0);
    chk({tag, " identity"}, AW'(net(32'h1234_5678, cfg_active)), AW'(32'h1234_5678));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    swap_en     = 1'b0;
    rst         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check_reset_state("reset");

    // Full set 0x0001..0x0009, swap three cycles after the last word.
    for (int i = 0; i < 8; i++) push(1, 16'(i + 1), 0, 0, 1, 0, 0, 8'd0);
    push(1, 16'h0009, 1, 0, 0, 1, 0, 8'd0);
    push(0, 16'h0, 0, 0, 0, 1, 0, 8'd0);
    push(0, 16'h0, 0, 0, 0, 1, 0, 8'd0);
    push(0, 16'h0, 0, 1, 1, 0, 0, 8'd1);
    run_table("full");
    chk("full cfg_active", cfg_active, exp_set(1));

    // Short set, then swap_en in LOAD is ignored, then a good set.
    push(1, 16'h0011, 0, 0, 1, 0, 0, 8'd1);
    push(1, 16'h0012, 0, 0, 1, 0, 0, 8'd1);
    push(1, 16'h0013, 0, 0, 1, 0, 0, 8'd1);
    push(1, 16'h0014, 1, 0, 1, 0, 1, 8'd1);
    push(0, 16'h0, 0, 1, 1, 0, 0, 8'd1);
    run_table("short");
    chk("short cfg_active kept", cfg_active, exp_set(1));
    for (int i = 0; i < 8; i++) push(1, 16'(16'h0100 + i), 0, 0, 1, 0, 0, 8'd1);
    push(1, 16'h0108, 1, 0, 0, 1, 0, 8'd1);
    push(0, 16'h0, 0, 1, 1, 0, 0, 8'd2);
    run_table("after_short");
    chk("after_short cfg_active", cfg_active, exp_set(16'h0100));

    // Long set: 11 words, error on the 9th, tail dropped.
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, 16'(16'h0200 + i), (i == 10), 1'b0);
      chk($sformatf("long[%0d] cfg_err", i), AW'(cfg_err), AW'(i == 8));
      chk($sformatf("long[%0d] cfg_pending", i), AW'(cfg_pending), '0);
      chk($sformatf("long[%0d] s_ready", i), AW'(bus.s_ready), AW'(1'b1));
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("long epoch", AW'(cfg_epoch), AW'(8'd2));
    chk("long cfg_active kept", cfg_active, exp_set(16'h0100));
    send_full(16'h0300);
    chk("after_long epoch", AW'(cfg_epoch), AW'(8'd3));
    chk("after_long cfg_active", cfg_active, exp_set(16'h0300));

    // swap_en coincident with the committing word, then held high.
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h0408, 1'b1, 1'b1);
    chk("coinc pending", AW'(cfg_pending), AW'(1'b1));
    chk("coinc epoch", AW'(cfg_epoch), AW'(8'd3));
    chk("coinc cfg_active", cfg_active, exp_set(16'h0300));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      chk($sformatf("held[%0d] epoch", i), AW'(cfg_epoch), AW'(8'd4));
      chk($sformatf("held[%0d] pending", i), AW'(cfg_pending), '0);
    end
    chk("held cfg_active", cfg_active, exp_set(16'h0400));

    // Reset part-way through a load.
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0500 + i), 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    check_reset_state("midreset");
    send_full(16'h0600);
    chk("post_reset epoch", AW'(cfg_epoch), AW'(8'd1));
    chk("post_reset cfg_active", cfg_active, exp_set(16'h0600));

    // 255 more swaps: epoch 1 -> 255 -> 0.
    for (int j = 1; j <= 255; j++) begin
      send_full(16'h1000 + j * 16);
      if (j == 254) chk("epoch 255", AW'(cfg_epoch), AW'(8'd255));
    end
    chk("epoch wrap", AW'(cfg_epoch), '0);
    chk("wrap cfg_active", cfg_active, exp_set(16'h1000 + 255 * 16));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
